// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv
// Purpose  : Iterative RV32M-style multiply/divide unit for a WIDTH-bit
//            datapath. Multiplies by shift-add and divides by restoring
//            subtraction, one iteration per cycle. Both work on operand
//            magnitudes, and the sign is fixed up in a final cycle.
// Ports    : clk, rst        - clock (rising edge), synchronous active-high reset
//            flush           - abandon any in-flight or completed operation
//            in_valid/ready  - request handshake (ready only while idle)
//            func_3          - 000 MUL 001 MULH 010 MULHSU 011 MULHU
//                              100 DIV 101 DIVU 110 REM  111 REMU
//            op_1, op_2      - rs1 (multiplicand/dividend), rs2 (multiplier/divisor)
//            out_valid/ready - result handshake
//            result          - operation result
//            div_zero        - divide-class op with op_2 == 0 (valid with out_valid)
//            busy            - unit not idle
// Options  : `define MULDIV_EARLY_OUT_EN resolves divide-by-zero, signed
//            overflow and multiply-by-zero at the accept edge (1-cycle latency).
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       func_3,
    input  logic [WIDTH-1:0] op_1,
    input  logic [WIDTH-1:0] op_2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t r_state;
    state_t w_next;

    logic [2:0]         r_func;
    logic               r_s1;
    logic               r_s2;
    logic [WIDTH-1:0]   r_a;       // |op_1|; for divide it shifts out dividend bits and collects quotient bits
    logic [WIDTH-1:0]   r_b;       // |op_2|
    logic [WIDTH-1:0]   r_op1;     // raw op_1, returned by REM/REMU on divide-by-zero
    logic [2*WIDTH-1:0] r_acc;     // product accumulator; low half starts as the multiplier
    logic [WIDTH:0]     r_rem;     // partial remainder
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_div_zero;

    // ---------------- accept-edge operand decode ----------------
    logic             w_accept;
    logic             w_s1_in;
    logic             w_s2_in;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;

    assign w_accept = in_valid && (r_state == S_IDLE) && !flush;
    assign w_s1_in  = op_1[WIDTH-1] && (func_3 == 3'b001 || func_3 == 3'b010 ||
                                        func_3 == 3'b100 || func_3 == 3'b110);
    assign w_s2_in  = op_2[WIDTH-1] && (func_3 == 3'b001 || func_3 == 3'b100 ||
                                        func_3 == 3'b110);
    // Negating MIN yields the same bit pattern, which read unsigned is 2^(WIDTH-1).
    assign w_mag1   = w_s1_in ? -op_1 : op_1;
    assign w_mag2   = w_s2_in ? -op_2 : op_2;

    // ---------------- early-out special cases ----------------
    logic             w_early;
    logic [WIDTH-1:0] w_early_result;
    logic             w_early_dz;

`ifdef MULDIV_EARLY_OUT_EN
    localparam logic [WIDTH-1:0] c_min = {1'b1, {(WIDTH-1){1'b0}}};
    logic w_op2_zero;
    logic w_ovf;
    assign w_op2_zero     = (op_2 == '0);
    assign w_ovf          = func_3[2] && !func_3[0] && (op_1 == c_min) && (op_2 == '1);
    assign w_early        = func_3[2] ? (w_op2_zero || w_ovf) : ((op_1 == '0) || w_op2_zero);
    assign w_early_result = !func_3[2] ? '0 :
                            w_op2_zero ? (func_3[1] ? op_1 : '1) :
                                         (func_3[1] ? '0 : c_min);
    assign w_early_dz     = func_3[2] && w_op2_zero;
`else
    assign w_early        = 1'b0;
    assign w_early_result = '0;
    assign w_early_dz     = 1'b0;
`endif

    // ---------------- iteration datapath ----------------
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH+1:0] w_div_shift;
    logic [WIDTH+1:0] w_div_diff;
    logic             w_qbit;

    assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_div_shift = {r_rem, r_a[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {2'b00, r_b};
    assign w_qbit      = ~w_div_diff[WIDTH+1];   // no borrow: divisor fits

    // ---------------- sign fix-up and output select ----------------
    logic               w_b_zero;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_remd;
    logic [WIDTH-1:0]   w_fix_result;
    logic               w_fix_dz;

    assign w_b_zero     = (r_b == '0);
    assign w_prod       = (r_s1 ^ r_s2) ? -r_acc : r_acc;
    assign w_quot       = w_b_zero ? '1 : ((r_s1 ^ r_s2) ? -r_a : r_a);
    assign w_remd       = w_b_zero ? r_op1 : (r_s1 ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0]);
    assign w_fix_result = r_func[2] ? (r_func[1] ? w_remd : w_quot)
                                    : ((r_func[1:0] == 2'b00) ? w_prod[WIDTH-1:0]
                                                              : w_prod[2*WIDTH-1:WIDTH]);
    assign w_fix_dz     = r_func[2] && w_b_zero;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept)            w_next = w_early ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == c_cnt_one)  w_next = S_FIX;
            S_FIX:                           w_next = S_DONE;
            S_DONE: if (out_ready)           w_next = S_IDLE;
            default:                         w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_func     <= '0;
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_op1      <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_div_zero <= 1'b0;
        end else if (flush) begin
            r_div_zero <= 1'b0;   // result deliberately keeps its last value
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_func <= func_3;
                    r_s1   <= w_s1_in;
                    r_s2   <= w_s2_in;
                    r_a    <= w_mag1;
                    r_b    <= w_mag2;
                    r_op1  <= op_1;
                    r_acc  <= {{WIDTH{1'b0}}, w_mag2};
                    r_rem  <= '0;
                    r_cnt  <= c_cnt_init;
                    if (w_early) begin
                        r_result   <= w_early_result;
                        r_div_zero <= w_early_dz;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_func[2]) begin
                        r_rem <= w_qbit ? w_div_diff[WIDTH:0] : w_div_shift[WIDTH:0];
                        r_a   <= {r_a[WIDTH-2:0], w_qbit};
                    end else begin
                        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    r_result   <= w_fix_result;
                    r_div_zero <= w_fix_dz;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = !in_ready;
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign div_zero  = r_div_zero;

endmodule
`default_nettype wire
